// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Byte-lane geometry and loader FSM encoding.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    DONE
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam int WORD_W = 8 * BYTES_PER_WORD;

  // Drop one byte into its little-endian lane of a word.
  function automatic logic [WORD_W-1:0] insert_byte(
    input logic [WORD_W-1:0] w,
    input logic [LANE_W-1:0] lane,
    input logic [7:0]        b
  );
    logic [WORD_W-1:0] r;
    r = w;
    r[int'(lane)*8 +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready link into the loader.
// master = host/UART side, slave = loader.
interface imem_loader_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes into little-endian words.
// Flags a word when lane 3 fills or the last byte lands.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              beat,
  input  logic              last,
  input  logic [7:0]        data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam logic [LANE_W-1:0] LANE_TOP =
    LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane;
  logic [WORD_W-1:0] acc;

  // Present the word with the current byte merged in;
  // the accumulator holds only lower lanes, so upper
  // lanes of a short final word read as zero.
  always_comb begin
    word       = insert_byte(acc, lane, data);
    word_valid = beat && (last || (lane == LANE_TOP));
  end

  // Advance the lane per beat; restart from lane 0 on
  // every completed word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane <= '0;
      acc  <= '0;
    end else if (clr) begin
      lane <= '0;
      acc  <= '0;
    end else if (word_valid) begin
      lane <= '0;
      acc  <= '0;
    end else if (beat) begin
      lane <= lane + 1'b1;
      acc  <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer.
// Holds the core in reset until the program is written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      in_if,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  loader_state_t     state;
  logic              ready_q;
  logic              beat;
  logic              full;
  logic              clr;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  assign in_if.in_ready = ready_q;

  // Handshake qualifiers; ready is a pure register.
  always_comb begin
    beat = in_if.in_valid && ready_q;
    full = (word_count == FULL);
    clr  = (state == DONE) && restart;
  end

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .beat       (beat),
    .last       (in_if.in_last),
    .data       (in_if.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Loader FSM with registered write port and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      ready_q    <= 1'b1;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        LOAD: begin
          if (beat && full) begin
            load_err <= 1'b1;
          end
          if (word_valid && !full) begin
            imem_we    <= 1'b1;
            imem_waddr <= word_count[ADDR_W-1:0];
            imem_wdata <= word;
            word_count <= word_count + 1'b1;
          end
          if (beat && in_if.in_last) begin
            state   <= DRAIN;
            ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          state     <= DONE;
          core_hold <= 1'b0;
          load_done <= 1'b1;
        end
        DONE: begin
          if (restart) begin
            state      <= LOAD;
            ready_q    <= 1'b1;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
          end
        end
        default: begin
          state   <= LOAD;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer: accepts a little-endian byte stream over a valid/ready handshake, packs it into 32-bit words, and drives the fetch stage's instruction-memory write port from word 0 upward. It sits between the host/UART front end and the fetch stage. It holds the pipeline in reset via `core_hold` until the program is fully written, replacing bench-side direct memory preloading with a synthesizable path.

## Interface
- `DEPTH`, 256: instruction-memory size in 32-bit words.
- `ADDR_W`, $clog2(DEPTH): word-address width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `in_valid` input 1: byte beat valid.
- `in_ready` output 1: loader can accept a beat.
- `in_data` input 8: program byte.
- `in_last` input 1: final byte of the program; qualified by `in_valid`.
- `restart` input 1: single-cycle pulse; honoured only in DONE.
- `imem_we` output 1: one-cycle write strobe to the instruction memory.
- `imem_waddr` output ADDR_W: word index.
- `imem_wdata` output 32: packed word.
- `core_hold` output 1: high keeps the pipeline in reset.
- `load_done` output 1: program fully written.
- `load_err` output 1: overflow; bytes beyond DEPTH words were dropped.
- `word_count` output ADDR_W+1: words written in the current load.

## Operation
- Reset values: state LOAD, `in_ready`=1, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `core_hold`=1, `load_done`=0, `load_err`=0, `word_count`=0, byte lane=0.
- States:
  - LOAD:
    - `in_ready`=1.
    - Beat accepted when `in_valid && in_ready`.
    - Byte lane k (0..3) fills bits [8k+7:8k]; the first byte lands in [7:0].
  - LOAD, word complete: when lane 3 is accepted, or `in_last` is accepted at any lane:
    - Next cycle `imem_we`=1 with `imem_waddr`=`word_count[ADDR_W-1:0]`.
    - `imem_wdata` is the packed word; unfilled upper lanes are zero.
    - `word_count` increments and the lane returns to 0.
  - LOAD, `in_last` accepted: go to DRAIN. `in_ready` drops to 0 in the same edge.
  - DRAIN: one cycle, which carries the final `imem_we`. Go to DONE.
  - DONE:
    - `core_hold`=0, `load_done`=1, `in_ready`=0.
    - `restart` → LOAD: counters, lane and `load_err` clear; `core_hold`=1; `load_done`=0.
- Overflow: a beat accepted while `word_count`==DEPTH is consumed but not written, and `load_err` sets sticky.
  - `in_ready` stays 1 so the stream drains to `in_last`.
  - DONE is still reached, with `load_err`=1.
- `restart` outside DONE is ignored.
- Reset asserted mid-load aborts immediately. No partial write is issued, and all outputs return to reset values.

## Timing
- Latency: `imem_we` is registered and pulses exactly 1 cycle after the accepting edge of the completing byte.
- Back-to-back writes occur at most every 4 cycles at full beat rate.
- `in_ready` is a registered-state decode, with no combinational path from `in_valid`.
- `in_valid` may stall between any bytes. The lane holds with no timeout.
- `core_hold` falls at the edge entering DONE, one cycle after the final `imem_we`, so the memory is written before fetch leaves reset.
- `load_done` rises in the same cycle that `core_hold` falls.

## Structure
- Package `imem_loader_pkg`:
  - `typedef enum logic [1:0] {LOAD, DRAIN, DONE} loader_state_t`
  - `localparam BYTES_PER_WORD = 4`
- Sub-module `byte_packer` (natural split):
  - Holds the lane counter and 32-bit shift/insert register.
  - Outputs `word_valid` and `word` on word completion or last byte, with zero-filled upper lanes.
- Top `imem_loader` holds the FSM, address/word counter, overflow flag and write-port registers.
- Instantiated ahead of `fetch`. Its `core_hold` is OR-ed into the pipeline reset in `top`.

## Test plan
- Stream bytes 93 00 80 3E 33 81 10 00 with `in_last` on the final byte, `in_valid` held high:
  - `imem_we` at address 0 with 32'h3e800093, then at address 1 with 32'h00108133.
  - `word_count`=2.
  - `core_hold` falls one cycle after the second write.
- Stream 5 bytes 13 05 00 00 AA with `in_last` on AA:
  - Second write is address 1, data 32'h000000aa.
  - `load_done`=1, `load_err`=0.
- Same 8 bytes with `in_valid` low for 3 cycles between each byte:
  - Identical writes.
  - No `imem_we` while stalled.
- DEPTH=4, stream 20 bytes:
  - Exactly 4 writes at addresses 0..3.
  - `load_err`=1, `load_done`=1, `word_count`=4.
- Assert `reset` low after 6 bytes, release, then stream 4 bytes 01 02 03 04 with last:
  - Single write at address 0 with 32'h04030201.
  - No stale data.
- In DONE, pulse `restart`, then stream 4 bytes:
  - `core_hold` returns to 1 and the write lands at address 0.
  - A `restart` pulse during LOAD has no effect.
